uart_tx: RTL and testbench

Serial transmitter producing 8N1 (optionally 8E1) frames on a single output line, paced by an internal baud-interval counter. It sits between on-chip producers (debug/trace logic, host link) and the board's UART pin. It is the transmit-side counterpart of the baud-rate event counting used on the receive path. Bytes are accepted through a valid/ready handshake and are shifted out LSB-first.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_baud_tick.sv | 40 ++++
 rtl/uart_tx.sv | 165 ++++++++++++++++
 tb/tb_uart_tx.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
package uart_pkg;

  localparam int UART_DEFAULT_BAUD_DIVISOR = 868;
  localparam int UART_DEFAULT_DATA_WIDTH   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Even parity bit; zero-extension of narrower payloads leaves the XOR unchanged.
  function automatic logic even_parity(input logic [63:0] value);
    return ^value;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Modulo-BAUD_DIVISOR bit-period counter; tick_out is high during the last cycle of each bit.
module uart_baud_tick #(
  parameter int BAUD_DIVISOR = 868
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clr_in,
  input  logic en_in,
  output logic tick_out
);

  localparam int CW = (BAUD_DIVISOR > 1) ? $clog2(BAUD_DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIVISOR - 1);
  localparam logic [CW-1:0] ONE  = CW'(32'd1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_in) begin
      cnt_d = '0;
    end else if (en_in) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_out = en_in && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: valid/ready byte input, LSB-first 8N1 serial output.
// Define UART_TX_PARITY_EN to append an even-parity bit (8E1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUD_DIVISOR = UART_DEFAULT_BAUD_DIVISOR,
  parameter int DATA_WIDTH   = UART_DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  output logic                  ready_out,
  output logic                  busy_out,
  output logic                  tx_out
);

  localparam int IW = $clog2(DATA_WIDTH + 1);
  localparam logic [IW-1:0] LAST_BIT = IW'(DATA_WIDTH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(32'd1);

  localparam logic [2:0] ST_IDLE   = 3'(IDLE);
  localparam logic [2:0] ST_START  = 3'(START);
  localparam logic [2:0] ST_DATA   = 3'(DATA);
  localparam logic [2:0] ST_STOP   = 3'(STOP);
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'(PARITY);
`endif

  logic [2:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IW-1:0]         bit_idx_q, bit_idx_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
`ifdef UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif
  logic                  accept_s;
  logic                  tick_s;

  assign accept_s = data_valid_in && ready_q;

  // Counter restarts on accept so the start bit is exactly one full period.
  uart_baud_tick #(
    .BAUD_DIVISOR(BAUD_DIVISOR)
  ) u_baud (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clr_in  (accept_s || tick_s),
    .en_in   (busy_q),
    .tick_out(tick_s)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d   = ST_START;
          shift_d   = data_in;
          bit_idx_d = '0;
          tx_d      = 1'b0;
          ready_d   = 1'b0;
          busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_d  = even_parity(64'(data_in));
`endif
        end else begin
          tx_d = 1'b1;
        end
      end
      ST_START: begin
        if (tick_s) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
        end else begin
          tx_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (tick_s) begin
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = parity_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + IDX_ONE;
            tx_d      = shift_d[0];
          end
        end else begin
          tx_d = shift_q[0];
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick_s) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
        end else begin
          tx_d = parity_q;
        end
      end
`endif
      ST_STOP: begin
        if (tick_s) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          ready_d = 1'b0;
        end
        tx_d = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign tx_out    = tx_q;
  assign ready_out = ready_q;
  assign busy_out  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at BAUD_DIVISOR=4; follows UART_TX_PARITY_EN when defined.
module tb_uart_tx;

  localparam int BD = 4;
  localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = DW + 3;
`else
  localparam int NBITS = DW + 2;
`endif
  localparam int FL = NBITS * BD;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [DW-1:0] data_in;
  logic          data_valid_in;
  logic          ready_out;
  logic          busy_out;
  logic          tx_out;

  int tests_run    = 0;
  int tests_failed = 0;

  logic cap_tx   [0:255];
  logic cap_rdy  [0:255];
  logic cap_busy [0:255];

  always #5 clk_in = ~clk_in;

  uart_tx #(
    .BAUD_DIVISOR(BD),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .data_in      (data_in),
    .data_valid_in(data_valid_in),
    .ready_out    (ready_out),
    .busy_out     (busy_out),
    .tx_out       (tx_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Record the line and handshake outputs for n cycles starting at cap index start.
  task automatic capture(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      cap_tx[start+i]   = tx_out;
      cap_rdy[start+i]  = ready_out;
      cap_busy[start+i] = busy_out;
      step();
    end
  endtask

  // Expected line level per frame bit position (start, data LSB-first, [parity], stop).
  function automatic logic [10:0] make_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // One-cycle handshake; returns in the first cycle after the accepting edge.
  task automatic send(input logic [7:0] d);
    data_in       = d;
    data_valid_in = 1'b1;
    step();
    data_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1;
    data_valid_in = 1'b0;
    for (int i = 0; i < 3; i++) step();
    rst_in = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tests_run++;
      if (tx_out !== 1'b1 || ready_out !== 1'b1 || busy_out !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: tx=%b ready=%b busy=%b, required tx=1 ready=1 busy=0",
                 i, tx_out, ready_out, busy_out);
      end
      step();
    end
  endtask

  task automatic test_single_byte(input logic [7:0] d);
    logic [10:0] fr;
    fr = make_frame(d);
    send(d);
    capture(0, FL + 1);
    for (int i = 0; i < FL; i++) begin
      tests_run++;
      if (cap_tx[i] !== fr[i/BD] || cap_rdy[i] !== 1'b0 || cap_busy[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL single_byte %h cycle %0d: tx=%b ready=%b busy=%b, required tx=%b ready=0 busy=1",
                 d, i, cap_tx[i], cap_rdy[i], cap_busy[i], fr[i/BD]);
      end
    end
    tests_run++;
    if (cap_tx[FL] !== 1'b1 || cap_rdy[FL] !== 1'b1 || cap_busy[FL] !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_byte_end %h: tx=%b ready=%b busy=%b, required tx=1 ready=1 busy=0",
               d, cap_tx[FL], cap_rdy[FL], cap_busy[FL]);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] fr0;
    logic [10:0] fr1;
    fr0 = make_frame(8'h00);
    fr1 = make_frame(8'hFF);
    data_in       = 8'h00;
    data_valid_in = 1'b1;
    step();
    data_in = 8'hFF;
    capture(0, FL + 1);
    data_valid_in = 1'b0;
    capture(FL + 1, FL + 1);
    for (int i = 0; i < FL; i++) begin
      tests_run++;
      if (cap_tx[i] !== fr0[i/BD]) begin
        tests_failed++;
        $display("FAIL b2b_first cycle %0d: tx=%b, required %b", i, cap_tx[i], fr0[i/BD]);
      end
    end
    tests_run++;
    if (cap_tx[FL] !== 1'b1 || cap_rdy[FL] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_gap: tx=%b ready=%b, required tx=1 ready=1", cap_tx[FL], cap_rdy[FL]);
    end
    for (int i = 0; i < FL; i++) begin
      tests_run++;
      if (cap_tx[FL+1+i] !== fr1[i/BD] || cap_rdy[FL+1+i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_second cycle %0d: tx=%b ready=%b, required tx=%b ready=0",
                 FL + 1 + i, cap_tx[FL+1+i], cap_rdy[FL+1+i], fr1[i/BD]);
      end
    end
    tests_run++;
    if (cap_tx[2*FL+1] !== 1'b1 || cap_rdy[2*FL+1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_end: tx=%b ready=%b, required tx=1 ready=1", cap_tx[2*FL+1], cap_rdy[2*FL+1]);
    end
    capture(0, 10);
    for (int i = 0; i < 10; i++) begin
      tests_run++;
      if (cap_tx[i] !== 1'b1 || cap_rdy[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_no_extra cycle %0d: tx=%b ready=%b, required tx=1 ready=1", i, cap_tx[i], cap_rdy[i]);
      end
    end
  endtask

  task automatic test_valid_while_busy();
    logic [10:0] fr;
    fr = make_frame(8'h81);
    send(8'h81);
    capture(0, 10);
    data_in       = 8'h3C;
    data_valid_in = 1'b1;
    capture(10, 1);
    data_valid_in = 1'b0;
    capture(11, FL + 20 - 11);
    for (int i = 0; i < FL; i++) begin
      tests_run++;
      if (cap_tx[i] !== fr[i/BD]) begin
        tests_failed++;
        $display("FAIL busy_ignore frame cycle %0d: tx=%b, required %b", i, cap_tx[i], fr[i/BD]);
      end
    end
    for (int i = FL; i < FL + 20; i++) begin
      tests_run++;
      if (cap_tx[i] !== 1'b1 || cap_rdy[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL busy_ignore idle cycle %0d: tx=%b ready=%b, required tx=1 ready=1", i, cap_tx[i], cap_rdy[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    send(8'hF0);
    capture(0, 1 + 4 * BD);
    tests_run++;
    if (cap_tx[4*BD] !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset bit3: tx=%b, required 0", cap_tx[4*BD]);
    end
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    tests_run++;
    if (tx_out !== 1'b1 || ready_out !== 1'b1 || busy_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_after: tx=%b ready=%b busy=%b, required tx=1 ready=1 busy=0",
               tx_out, ready_out, busy_out);
    end
    capture(0, 2 * FL);
    for (int i = 0; i < 2 * FL; i++) begin
      tests_run++;
      if (cap_tx[i] !== 1'b1 || cap_rdy[i] !== 1'b1) begin
        tests_failed++;
        $display("FAIL mid_reset_idle cycle %0d: tx=%b ready=%b, required tx=1 ready=1", i, cap_tx[i], cap_rdy[i]);
      end
    end
    test_single_byte(8'h5A);
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity(input logic [7:0] d, input logic exp_par);
    send(d);
    capture(0, FL + 1);
    for (int j = 0; j < BD; j++) begin
      tests_run++;
      if (cap_tx[9*BD+j] !== exp_par) begin
        tests_failed++;
        $display("FAIL parity %h cycle %0d: tx=%b, required %b", d, 9 * BD + j, cap_tx[9*BD+j], exp_par);
      end
    end
    tests_run++;
    if (cap_rdy[43] !== 1'b0 || cap_rdy[44] !== 1'b1 || cap_tx[43] !== 1'b1) begin
      tests_failed++;
      $display("FAIL parity_len %h: ready[43]=%b ready[44]=%b tx[43]=%b, required 0 1 1",
               d, cap_rdy[43], cap_rdy[44], cap_tx[43]);
    end
  endtask
`endif

  initial begin
    rst_in        = 1'b1;
    data_in       = 8'h00;
    data_valid_in = 1'b0;
    test_reset();
    test_single_byte(8'hA5);
    test_back_to_back();
    test_valid_while_busy();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity(8'h07, 1'b1);
    test_parity(8'h03, 1'b0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
